// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256 message schedule block:
//   - word_t   : 32-bit schedule word
//   - state_t  : msg_schedule FSM state encoding
//   - sigma0 / sigma1 : small sigma functions used by the W[t] recurrence
package sha256_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXPAND,
      DONE
   } state_t;

   // Window depth and index of the last schedule word.
   localparam int unsigned WIN_WORDS = 16;
   localparam logic [5:0]  LAST_IDX  = 6'd63;

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t sigma0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t sigma1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/msg_sigma.sv
// msg_sigma
//   Combinational update term for the 16-word schedule window:
//   o_next = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0]  (mod 2^32)
// Ports:
//   i_w0, i_w1, i_w9, i_w14 : window taps
//   o_next                  : next word appended at w[15]
module msg_sigma
   import sha256_pkg::*;
(
   input  word_t i_w0,
   input  word_t i_w1,
   input  word_t i_w9,
   input  word_t i_w14,
   output word_t o_next
);

   assign o_next = sigma1(i_w14) + i_w9 + sigma0(i_w1) + i_w0;

endmodule

// File: rtl/msg_schedule.sv
// msg_schedule
//   Reads a 64-byte padded block from byte-wide memory and streams the 64
//   SHA-256 schedule words W[0..63] over a valid/ready handshake.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : level request to expand the block in memory
//   finish       : high in DONE until start is dropped
//   memAddrLine  : read address, high-Z when not loading
//   memDataLine  : read data, one cycle after its address
//   wOut, wIdx   : schedule word W[t] and its index t
//   wValid       : wOut/wIdx valid
//   wReady       : consumer accepts when wValid && wReady at posedge
module msg_schedule
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned BLOCK_SIZE = 64,
   parameter int unsigned BASE_ADDR  = 0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  finish,
   output logic [ADDR_WIDTH-1:0] memAddrLine,
   input  logic [DATA_WIDTH-1:0] memDataLine,
   output logic [31:0]           wOut,
   output logic [5:0]            wIdx,
   output logic                  wValid,
   input  logic                  wReady
);

   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [6:0]            LOAD_LAST = 7'(BLOCK_SIZE);

   state_t r_state;
   state_t w_next;

   logic [6:0] r_cnt;
   logic [5:0] r_t;
   word_t      r_win [WIN_WORDS];

   word_t                 w_new;
   logic                  w_accept;
   logic                  w_drive;
   logic [ADDR_WIDTH-1:0] w_addr;

   msg_sigma u_sigma (
      .i_w0   (r_win[0]),
      .i_w1   (r_win[1]),
      .i_w9   (r_win[9]),
      .i_w14  (r_win[14]),
      .o_next (w_new)
   );

   // Address wraps naturally at ADDR_WIDTH bits.
   assign w_addr      = BASE + ADDR_WIDTH'(r_cnt);
   assign w_drive     = (r_state == LOAD) && (r_cnt < LOAD_LAST);
   assign memAddrLine = w_drive ? w_addr : 'z;
   assign w_accept    = wValid && wReady;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      finish = 1'b0;
      wValid = 1'b0;
      wOut   = r_win[0];
      wIdx   = r_t;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = LOAD;
         end
         LOAD: begin
            if (r_cnt == LOAD_LAST) w_next = EXPAND;
         end
         EXPAND: begin
            wValid = 1'b1;
            if (wReady && (r_t == LAST_IDX)) w_next = DONE;
         end
         DONE: begin
            finish = 1'b1;
            if (!start) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_t   <= '0;
         for (int unsigned i = 0; i < WIN_WORDS; i++) begin
            r_win[i] <= '0;
         end
      end else begin
         unique case (r_state)
            IDLE: begin
               r_cnt <= '0;
               r_t   <= '0;
            end
            LOAD: begin
               r_cnt <= r_cnt + 7'd1;
               // Bytes are shifted in one at a time across the whole window,
               // so after 64 captures byte 0 sits in w[0][31:24] (big-endian).
               if (r_cnt != 7'd0) begin
                  for (int unsigned i = 0; i < WIN_WORDS - 1; i++) begin
                     r_win[i] <= {r_win[i][23:0], r_win[i+1][31:24]};
                  end
                  r_win[WIN_WORDS-1] <= {r_win[WIN_WORDS-1][23:0], memDataLine[7:0]};
               end
            end
            EXPAND: begin
               if (w_accept) begin
                  for (int unsigned i = 0; i < WIN_WORDS - 1; i++) begin
                     r_win[i] <= r_win[i+1];
                  end
                  r_win[WIN_WORDS-1] <= w_new;
                  // Index saturates at 63 so wIdx does not wrap on the last accept.
                  if (r_t != LAST_IDX) r_t <= r_t + 6'd1;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_schedule.sv
module tb_msg_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        finish;
   wire  [9:0]  memAddrLine;
   logic [7:0]  memDataLine;
   logic [31:0] wOut;
   logic [5:0]  wIdx;
   logic        wValid;
   logic        wReady;

   logic        start2;
   logic        finish2;
   wire  [9:0]  memAddrLine2;
   logic [7:0]  memDataLine2;
   logic [31:0] wOut2;
   logic [5:0]  wIdx2;
   logic        wValid2;
   logic        wReady2;

   logic [7:0]  mem [0:1023];
   logic [31:0] W   [64];
   logic [31:0] got [64];

   int n_cmp = 0;
   int n_err = 0;
   int beats;

   msg_schedule #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (10),
      .BLOCK_SIZE (64),
      .BASE_ADDR  (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .finish      (finish),
      .memAddrLine (memAddrLine),
      .memDataLine (memDataLine),
      .wOut        (wOut),
      .wIdx        (wIdx),
      .wValid      (wValid),
      .wReady      (wReady)
   );

   msg_schedule #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (10),
      .BLOCK_SIZE (64),
      .BASE_ADDR  (1000)
   ) dut2 (
      .clk         (clk),
      .rst         (rst),
      .start       (start2),
      .finish      (finish2),
      .memAddrLine (memAddrLine2),
      .memDataLine (memDataLine2),
      .wOut        (wOut2),
      .wIdx        (wIdx2),
      .wValid      (wValid2),
      .wReady      (wReady2)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data one cycle after address.
   always @(posedge clk) begin
      memDataLine  <= mem[memAddrLine];
      memDataLine2 <= mem[memAddrLine2];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference schedule from the textbook recurrence over a full 64-entry array.
   task automatic build_model();
      for (int k = 0; k < 16; k++)
         W[k] = {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]};
      for (int t = 16; t < 64; t++)
         W[t] = (rr(W[t-2], 17) ^ rr(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7]
              + (rr(W[t-15], 7) ^ rr(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
   endtask

   task automatic fill_abc();
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[0]  = 8'h61;
      mem[1]  = 8'h62;
      mem[2]  = 8'h63;
      mem[3]  = 8'h80;
      mem[63] = 8'h18;
   endtask

   task automatic fill_zero();
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
   endtask

   // One full block: load, stream 64 words (optional 5-cycle stall), finish.
   task automatic do_run(input int stall_at, input bit keep_start, output int nbeats);
      nbeats = 0;
      start = 1'b1;
      @(negedge clk);
      if (!keep_start) start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         chk($sformatf("addr_%0d", k), 32'(memAddrLine), 32'(k));
         @(negedge clk);
      end
      chk("load_no_valid", 32'(wValid), 32'd0);
      @(negedge clk);
      for (int t = 0; t < 64; t++) begin
         if (t == stall_at) begin
            wReady = 1'b0;
            for (int s = 0; s < 5; s++) begin
               chk($sformatf("stall_idx_%0d", s), 32'(wIdx), 32'(t));
               chk($sformatf("stall_word_%0d", s), wOut, W[t]);
               @(negedge clk);
            end
            wReady = 1'b1;
         end
         chk($sformatf("valid_%0d", t), 32'(wValid), 32'd1);
         chk($sformatf("idx_%0d", t), 32'(wIdx), 32'(t));
         chk($sformatf("word_%0d", t), wOut, W[t]);
         got[t] = wOut;
         if (wValid && wReady) nbeats++;
         @(negedge clk);
      end
      chk("done_valid", 32'(wValid), 32'd0);
      chk("done_finish", 32'(finish), 32'd1);
      chk("done_idx", 32'(wIdx), 32'd63);
      if (keep_start) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("hold_finish_%0d", c), 32'(finish), 32'd1);
            chk($sformatf("hold_valid_%0d", c), 32'(wValid), 32'd0);
         end
         start = 1'b0;
      end
      @(negedge clk);
      chk("idle_finish", 32'(finish), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      wReady  = 1'b1;
      start2  = 1'b0;
      wReady2 = 1'b1;
      fill_abc();
      build_model();

      repeat (3) @(negedge clk);
      chk("rst_finish", 32'(finish), 32'd0);
      chk("rst_valid", 32'(wValid), 32'd0);
      chk("rst_wout", wOut, 32'd0);
      chk("rst_widx", 32'(wIdx), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_start", 32'(wValid) | 32'(finish), 32'd0);

      // Wrapping base address on the second instance.
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int k = 0; k < 64; k++) begin
         chk($sformatf("addr2_%0d", k), 32'(memAddrLine2), 32'((1000 + k) % 1024));
         @(negedge clk);
      end

      // "abc" block, start dropped mid-operation.
      do_run(-1, 1'b0, beats);
      chk("abc_beats", 32'(beats), 32'd64);
      chk("abc_W0", got[0], 32'h61626380);
      chk("abc_W15", got[15], 32'h00000018);
      chk("abc_W16", got[16], 32'h61626380);
      chk("abc_W17", got[17], 32'h000F0000);
      chk("abc_W18", got[18], 32'h7DA86405);
      chk("abc_W63", got[63], 32'h12B1EDEB);

      // Back-pressure at t=20.
      do_run(20, 1'b0, beats);
      chk("stall_beats", 32'(beats), 32'd64);

      // Reset mid-LOAD, then a fresh start.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      chk("mid_addr", 32'(memAddrLine), 32'd30);
      #2 rst = 1'b1;
      #1;
      chk("arst_finish", 32'(finish), 32'd0);
      chk("arst_valid", 32'(wValid), 32'd0);
      chk("arst_wout", wOut, 32'd0);
      chk("arst_widx", 32'(wIdx), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", 32'(wValid) | 32'(finish), 32'd0);
      do_run(-1, 1'b0, beats);
      chk("reload_W63", got[63], 32'h12B1EDEB);

      // start held through DONE.
      do_run(-1, 1'b1, beats);
      chk("hold_beats", 32'(beats), 32'd64);

      // All-zero block.
      fill_zero();
      build_model();
      do_run(-1, 1'b0, beats);
      chk("zero_beats", 32'(beats), 32'd64);
      chk("zero_W63", got[63], 32'h00000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
